instruction_fetch_stage: RTL and testbench

//  IF pipeline stage placed directly upstream of InstructionMemoryFile.
//  - Owns the PC and drives the byte address into the memory.
//  - Captures the combinational 32-bit instruction word into the IF/ID register.
//  - Handles stall, flush and branch/jump redirect from later stages.
//  - Holds the PC across IMemError (miss) cycles and gives up after a bounded wait.

---
 rtl/instruction_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// IF pipeline stage: owns the PC, registers the instruction word into IF/ID, and handles stall/flush/redirect/miss.
// Optional macro IF_BOUNDS_CHECK_EN halts fetch on a misaligned or out-of-range PC.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES   = 64,
    parameter int unsigned MISS_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemData,
    input  logic        IMemError,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PC4,
    output logic        IFID_Valid,
    output logic        FetchFault
);

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_MISS_WAIT = 2'd1,
        ST_HALT      = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] r_pc4;
    logic [31:0] w_pc4_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        r_fault;
    logic        w_fault_nxt;
    logic [7:0]  r_miss_cnt;
    logic [7:0]  w_miss_cnt_nxt;
    logic [8:0]  w_miss_inc;
    logic        w_timeout;
    logic        w_bounds_fault;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_miss_inc = {1'b0, r_miss_cnt} + 9'd1;
    assign w_timeout  = (w_miss_inc >= 9'(MISS_TIMEOUT));

`ifdef IF_BOUNDS_CHECK_EN
    localparam logic [31:0] LP_PC_MAX = 32'(IMEM_BYTES - 4);
    assign w_bounds_fault = (r_pc[1:0] != 2'b00) || (r_pc > LP_PC_MAX);
`else
    assign w_bounds_fault = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bounds fault outranks Redirect; Stall keeps whatever state we are in.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_HALT) begin
            w_state_nxt = ST_HALT;
        end else if (w_bounds_fault) begin
            w_state_nxt = ST_HALT;
        end else if (Redirect) begin
            w_state_nxt = ST_FETCH;
        end else if (Stall) begin
            w_state_nxt = r_state;
        end else if (IMemError) begin
            w_state_nxt = w_timeout ? ST_HALT : ST_MISS_WAIT;
        end else begin
            w_state_nxt = ST_FETCH;
        end
    end

    always_comb begin
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_pc4_nxt      = r_pc4;
        w_valid_nxt    = r_valid;
        w_miss_cnt_nxt = r_miss_cnt;
        w_fault_nxt    = r_fault;
        if (r_state == ST_HALT || w_bounds_fault) begin
            w_valid_nxt = 1'b0;
            w_fault_nxt = 1'b1;
        end else if (Redirect) begin
            w_pc_nxt       = RedirectPC;
            w_valid_nxt    = 1'b0;
            w_miss_cnt_nxt = '0;
        end else if (Stall) begin
            if (Flush) begin
                w_valid_nxt = 1'b0;
            end
        end else if (IMemError) begin
            w_valid_nxt    = 1'b0;
            w_miss_cnt_nxt = w_miss_inc[7:0];
            if (w_timeout) begin
                w_fault_nxt = 1'b1;
            end
        end else begin
            w_instr_nxt    = IMemData;
            w_pc4_nxt      = w_pc_plus4;
            w_valid_nxt    = ~Flush;
            w_pc_nxt       = w_pc_plus4;
            w_miss_cnt_nxt = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_pc4      <= '0;
            r_valid    <= 1'b0;
            r_miss_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_pc4      <= w_pc4_nxt;
            r_valid    <= w_valid_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign IMemAddress = r_pc;
    assign IFID_Instr  = r_instr;
    assign IFID_PC4    = r_pc4;
    assign IFID_Valid  = r_valid;
    assign FetchFault  = r_fault;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: memory returns 0xA000_0000 + address for any address.
module tb_instruction_fetch_stage;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
    } obs_t;

    logic        Clk;
    logic        Rst;
    logic [31:0] IMemAddress;
    logic [31:0] IMemData;
    logic        IMemError;
    logic        Stall;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PC4;
    logic        IFID_Valid;
    logic        FetchFault;

    int   n_cmp;
    int   n_err;
    obs_t exp_q[$];
    obs_t got;
    obs_t want;

    instruction_fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_BYTES  (64),
        .MISS_TIMEOUT(15)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .IMemAddress(IMemAddress),
        .IMemData   (IMemData),
        .IMemError  (IMemError),
        .Stall      (Stall),
        .Flush      (Flush),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .IFID_Instr (IFID_Instr),
        .IFID_PC4   (IFID_PC4),
        .IFID_Valid (IFID_Valid),
        .FetchFault (FetchFault)
    );

    assign IMemData = 32'hA000_0000 + IMemAddress;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic obs_t mk(input logic [31:0] a, input logic [31:0] i,
                                input logic [31:0] p, input logic v, input logic f);
        mk = '{addr: a, instr: i, pc4: p, valid: v, fault: f};
    endfunction

    function automatic logic [31:0] w(input logic [31:0] a);
        w = 32'hA000_0000 + a;
    endfunction

    function automatic obs_t observe();
        observe = '{addr: IMemAddress, instr: IFID_Instr, pc4: IFID_PC4,
                    valid: IFID_Valid, fault: FetchFault};
    endfunction

    task automatic drive(input logic st, input logic fl, input logic rd,
                         input logic [31:0] rpc, input logic er);
        Stall = st; Flush = fl; Redirect = rd; RedirectPC = rpc; IMemError = er;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        #2;
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1 Rst = 1'b0;
        #2;
        exp_q.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL reset: got %h want %h", got, want);
        end
        @(negedge Clk);
        Rst = 1'b1;
        for (int unsigned k = 1; k <= 3; k++) begin
            exp_q.push_back(mk(32'(4*k), w(32'(4*(k-1))), 32'(4*k), 1'b1, 1'b0));
            tick();
            got = observe(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL freerun%0d: got %h want %h", k, got, want);
            end
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        for (int unsigned k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        // PC=8, IF/ID holds word(4)
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(mk(32'h8, w(32'h4), 32'h8, 1'b1, 1'b0));
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL stall1: got %h want %h", got, want);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(mk(32'h8, w(32'h4), 32'h8, 1'b0, 1'b0));
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL stall_flush: got %h want %h", got, want);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(mk(32'hC, w(32'h8), 32'hC, 1'b1, 1'b0));
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL stall_release: got %h want %h", got, want);
        end
        // Flush alone drops the word but the PC still advances
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(mk(32'h10, w(32'hC), 32'h10, 1'b0, 1'b0));
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL flush_only: got %h want %h", got, want);
        end
    endtask

    task automatic test_redirect();
        drive(1'b1, 1'b0, 1'b1, 32'h20, 1'b1);
        exp_q.push_back(mk(32'h20, w(32'hC), 32'h10, 1'b0, 1'b0));
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL redirect_stall: got %h want %h", got, want);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(mk(32'h24, w(32'h20), 32'h24, 1'b1, 1'b0));
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL redirect_fetch: got %h want %h", got, want);
        end
    endtask

    task automatic test_miss();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        for (int unsigned k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            exp_q.push_back(mk(32'h4, w(32'h0), 32'h4, 1'b0, 1'b0));
            tick();
            got = observe(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL miss%0d: got %h want %h", k, got, want);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(mk(32'h8, w(32'h4), 32'h8, 1'b1, 1'b0));
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL miss_recover: got %h want %h", got, want);
        end
    endtask

    task automatic test_timeout();
        // Counter must restart from 0 after the earlier recovery: fault only on the 15th miss
        for (int unsigned k = 1; k <= 15; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            exp_q.push_back(mk(32'h8, w(32'h4), 32'h8, 1'b0, (k == 15)));
            tick();
            got = observe(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL timeout_miss%0d: got %h want %h", k, got, want);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
        exp_q.push_back(mk(32'h8, w(32'h4), 32'h8, 1'b0, 1'b1));
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL halt_redirect: got %h want %h", got, want);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(mk(32'h8, w(32'h4), 32'h8, 1'b0, 1'b1));
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL halt_hold: got %h want %h", got, want);
        end
        #2 Rst = 1'b0;
        #1;
        exp_q.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL async_reset: got %h want %h", got, want);
        end
        @(negedge Clk);
        Rst = 1'b1;
        exp_q.push_back(mk(32'h4, w(32'h0), 32'h4, 1'b1, 1'b0));
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL after_reset: got %h want %h", got, want);
        end
    endtask

    task automatic test_bounds();
        logic [31:0] tgt [2];
        tgt[0] = 32'h3E;
        tgt[1] = 32'h40;
        for (int unsigned t = 0; t < 2; t++) begin
            do_reset();
            drive(1'b0, 1'b0, 1'b1, tgt[t], 1'b0);
            exp_q.push_back(mk(tgt[t], 32'h0, 32'h0, 1'b0, 1'b0));
            tick();
            got = observe(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL bounds_redirect%0d: got %h want %h", t, got, want);
            end
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef IF_BOUNDS_CHECK_EN
            exp_q.push_back(mk(tgt[t], 32'h0, 32'h0, 1'b0, 1'b1));
`else
            exp_q.push_back(mk(tgt[t] + 32'd4, w(tgt[t]), tgt[t] + 32'd4, 1'b1, 1'b0));
`endif
            tick();
            got = observe(); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL bounds_fetch%0d: got %h want %h", t, got, want);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef IF_BOUNDS_CHECK_EN
        exp_q.push_back(mk(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b1));
`else
        exp_q.push_back(mk(32'h0, w(32'hFFFF_FFFC), 32'h0, 1'b1, 1'b0));
`endif
        tick();
        got = observe(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL pc_wrap: got %h want %h", got, want);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stall_flush();
        test_redirect();
        test_miss();
        test_timeout();
        test_bounds();
        test_wrap();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
